// File: rtl/frame_capture_sequencer_if.sv
// ============================================================================
// Module : frame_capture_sequencer_if
// Brief  : Mask-RAM write port and neural-net start/done handshake bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface frame_capture_sequencer_if #(
  parameter int ADDR_BITS  = 11,
  parameter int CLASS_BITS = 3
);
  logic                  mask_we;
  logic [ADDR_BITS-1:0]  mask_addr;
  logic                  mask_bit;
  logic                  nn_start;
  logic                  nn_done;
  logic [CLASS_BITS-1:0] nn_class;

  modport master (
    output mask_we, mask_addr, mask_bit, nn_start,
    input  nn_done, nn_class
  );

  modport slave (
    input  mask_we, mask_addr, mask_bit, nn_start,
    output nn_done, nn_class
  );
endinterface

`default_nettype wire

// File: rtl/frame_capture_sequencer.sv
// ============================================================================
// Module : frame_capture_sequencer
// Brief  : Deserialises Pi bit-bang HSV pixels, writes a hand mask, then runs
//          the neural-net core once per frame and latches its class.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module frame_capture_sequencer #(
  parameter int         WIDTH          = 40,
  parameter int         LENGTH         = 45,
  parameter int         ADDR_BITS      = 11,
  parameter int         CLASS_BITS     = 3,
  parameter logic [7:0] MIN_HUE        = 8'd0,
  parameter logic [7:0] MAX_HUE        = 8'd25,
  parameter logic [7:0] MIN_SAT        = 8'd40,
  parameter logic [7:0] MAX_SAT        = 8'd255,
  parameter logic [7:0] MIN_VAL        = 8'd60,
  parameter logic [7:0] MAX_VAL        = 8'd255,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  wire logic                   fpga_clk,
  input  wire logic                   rst_n,
  input  wire logic                   pi_clk,
  input  wire logic                   data_in,
  input  wire logic                   write_enable,
  frame_capture_sequencer_if.master   bus,
  output logic [CLASS_BITS-1:0]       result,
  output logic                        result_valid,
  output logic [7:0]                  frame_count,
  output logic                        overrun,
  output logic                        timeout_err,
  output logic                        busy
);

  localparam int NPIX    = WIDTH * LENGTH;
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CAPTURE   = 2'd1;
  localparam logic [1:0] S_INFER     = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [2:0]            pclk_sync_q;   // [0],[1] synchroniser, [2] previous sample
  logic [1:0]            data_sync_q;
  logic [1:0]            we_sync_q;
  logic [23:0]           hsv_q, hsv_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_BITS-1:0]  pixel_idx_q, pixel_idx_d;
  logic [WD_BITS-1:0]    wd_q, wd_d;
  logic [CLASS_BITS-1:0] result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_err_q, timeout_err_d;

  logic w_edge, w_pix_done, w_last_pix, w_timeout, w_in_range;

  // Borrow-bit compares keep the bounds inclusive at 0 and 255.
  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    logic [8:0] below;
    logic [8:0] above;
    below = {1'b0, v} - {1'b0, lo};
    above = {1'b0, hi} - {1'b0, v};
    return ~below[8] & ~above[8];
  endfunction

  assign w_edge     = pclk_sync_q[1] & ~pclk_sync_q[2] & we_sync_q[1];
  assign w_pix_done = (state_q == S_CAPTURE) && (bit_cnt_q == 5'd24);
  assign w_last_pix = (pixel_idx_q == ADDR_BITS'(NPIX - 1));
  assign w_timeout  = (state_q == S_CAPTURE) && (wd_q == WD_BITS'(TIMEOUT_CYCLES));
  assign w_in_range = in_range(hsv_q[7:0], MIN_HUE, MAX_HUE)
                    & in_range(hsv_q[15:8], MIN_SAT, MAX_SAT)
                    & in_range(hsv_q[23:16], MIN_VAL, MAX_VAL);

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_sync_q <= '0;
      data_sync_q <= '0;
      we_sync_q   <= '0;
    end else begin
      pclk_sync_q <= {pclk_sync_q[1:0], pi_clk};
      data_sync_q <= {data_sync_q[0], data_in};
      we_sync_q   <= {we_sync_q[0], write_enable};
    end
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (w_edge) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (w_timeout)                    state_d = S_IDLE;
        else if (w_pix_done && w_last_pix) state_d = S_INFER;
      end
      S_INFER:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.nn_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hsv_d          = hsv_q;
    bit_cnt_d      = bit_cnt_q;
    pixel_idx_d    = pixel_idx_q;
    wd_d           = wd_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    frame_count_d  = frame_count_q;
    overrun_d      = overrun_q;
    timeout_err_d  = timeout_err_q;
    unique case (state_q)
      S_IDLE, S_CAPTURE: begin
        wd_d = (state_q == S_CAPTURE && !w_edge) ? wd_q + WD_BITS'(1) : '0;
        if (w_timeout) begin
          hsv_d         = '0;
          bit_cnt_d     = '0;
          pixel_idx_d   = '0;
          wd_d          = '0;
          timeout_err_d = 1'b1;
        end else if (w_pix_done) begin
          bit_cnt_d   = '0;
          pixel_idx_d = w_last_pix ? '0 : pixel_idx_q + ADDR_BITS'(1);
        end else if (w_edge) begin
          hsv_d[bit_cnt_q] = data_sync_q[1];
          bit_cnt_d        = bit_cnt_q + 5'd1;
        end
      end
      S_INFER: begin
        result_valid_d = 1'b0;
        if (w_edge) overrun_d = 1'b1;
      end
      S_WAIT_DONE: begin
        if (w_edge) overrun_d = 1'b1;
        if (bus.nn_done) begin
          result_d       = bus.nn_class;
          result_valid_d = 1'b1;
          frame_count_d  = frame_count_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsv_q          <= '0;
      bit_cnt_q      <= '0;
      pixel_idx_q    <= '0;
      wd_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      frame_count_q  <= '0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      hsv_q          <= hsv_d;
      bit_cnt_q      <= bit_cnt_d;
      pixel_idx_q    <= pixel_idx_d;
      wd_q           <= wd_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      frame_count_q  <= frame_count_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Outputs decode from reset registers, so they all read 0 while rst_n is low.
  always_comb begin
    bus.mask_we   = w_pix_done;
    bus.mask_addr = pixel_idx_q;
    bus.mask_bit  = w_pix_done & w_in_range;
    bus.nn_start  = (state_q == S_INFER);
    busy          = (state_q == S_INFER) || (state_q == S_WAIT_DONE);
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign frame_count  = frame_count_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_capture_sequencer.sv
// ============================================================================
// Module : tb_frame_capture_sequencer
// Brief  : Self-checking bench: directed and random pixel frames against a
//          behavioural mask/frame model; a 1x1 instance exercises count wrap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_frame_capture_sequencer;

  localparam int W0 = 4, L0 = 2, AB0 = 3, CB = 3, TO0 = 50;
  localparam int NP0 = W0 * L0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pclk0, dat0, we0, pclk1, dat1, we1;
  logic [CB-1:0] res0, res1;
  logic rv0, rv1, ov0, ov1, to0, to1, busy0, busy1;
  logic [7:0] fc0, fc1;

  frame_capture_sequencer_if #(.ADDR_BITS(AB0), .CLASS_BITS(CB)) bus0 ();
  frame_capture_sequencer_if #(.ADDR_BITS(1),   .CLASS_BITS(CB)) bus1 ();

  frame_capture_sequencer #(.WIDTH(W0), .LENGTH(L0), .ADDR_BITS(AB0), .CLASS_BITS(CB),
                            .TIMEOUT_CYCLES(TO0)) dut0 (
    .fpga_clk(clk), .rst_n(rst_n), .pi_clk(pclk0), .data_in(dat0), .write_enable(we0),
    .bus(bus0), .result(res0), .result_valid(rv0), .frame_count(fc0),
    .overrun(ov0), .timeout_err(to0), .busy(busy0));

  frame_capture_sequencer #(.WIDTH(1), .LENGTH(1), .ADDR_BITS(1), .CLASS_BITS(CB)) dut1 (
    .fpga_clk(clk), .rst_n(rst_n), .pi_clk(pclk1), .data_in(dat1), .write_enable(we1),
    .bus(bus1), .result(res1), .result_valid(rv1), .frame_count(fc1),
    .overrun(ov1), .timeout_err(to1), .busy(busy1));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_wr_cyc = 0, start_cyc = 0, start_cnt0 = 0, start_cnt1 = 0, wr_cnt1 = 0;
  int wr_addr_q[$];
  bit wr_bit_q[$];
  int exp_addr_q[$];
  bit exp_bit_q[$];
  int model_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus0.mask_we === 1'b1) begin
      wr_addr_q.push_back(int'(bus0.mask_addr));
      wr_bit_q.push_back(bus0.mask_bit);
      last_wr_cyc <= cyc;
    end
    if (bus0.nn_start === 1'b1) begin
      start_cnt0 <= start_cnt0 + 1;
      start_cyc  <= cyc;
    end
    if (bus1.mask_we === 1'b1) wr_cnt1 <= wr_cnt1 + 1;
    if (bus1.nn_start === 1'b1) start_cnt1 <= start_cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int d, input bit b);
    if (d == 0) begin dat0 = b; we0 = 1'b1; pclk0 = 1'b1; end
    else        begin dat1 = b; we1 = 1'b1; pclk1 = 1'b1; end
    tick(2);
    if (d == 0) pclk0 = 1'b0; else pclk1 = 1'b0;
    tick(2);
  endtask

  task automatic send_pixel(input int d, input logic [23:0] px);
    for (int k = 0; k < 24; k++) send_bit(d, px[k]);
  endtask

  // Reference classification: plain inclusive range test on the three fields.
  function automatic bit model_mask(input logic [23:0] px);
    int h, s, v;
    h = int'(px[7:0]);
    s = int'(px[15:8]);
    v = int'(px[23:16]);
    return (h >= 0 && h <= 25) && (s >= 40 && s <= 255) && (v >= 60 && v <= 255);
  endfunction

  function automatic logic [7:0] rfield(input int lo, input int hi);
    if ($urandom_range(0, 2) != 0) return 8'($urandom_range(hi, lo));
    return 8'($urandom_range(255, 0));
  endfunction

  function automatic logic [23:0] rand_px();
    return {rfield(60, 255), rfield(40, 255), rfield(0, 25)};
  endfunction

  task automatic expect_pixel(input logic [23:0] px);
    exp_addr_q.push_back(model_addr);
    exp_bit_q.push_back(model_mask(px));
    model_addr = (model_addr + 1) % NP0;
  endtask

  task automatic send_pixel_m(input logic [23:0] px);
    send_pixel(0, px);
    expect_pixel(px);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(exp_addr_q.size()));
    while (wr_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      chk({tag, "_addr"}, 64'(wr_addr_q.pop_front()), 64'(exp_addr_q.pop_front()));
      chk({tag, "_bit"},  64'(wr_bit_q.pop_front()),  64'(exp_bit_q.pop_front()));
    end
    wr_addr_q.delete(); wr_bit_q.delete(); exp_addr_q.delete(); exp_bit_q.delete();
  endtask

  task automatic pulse_done(input int d, input logic [CB-1:0] cls);
    if (d == 0) begin bus0.nn_class = cls; bus0.nn_done = 1'b1; end
    else        begin bus1.nn_class = cls; bus1.nn_done = 1'b1; end
    tick(1);
    if (d == 0) bus0.nn_done = 1'b0; else bus1.nn_done = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [23:0] px;
    logic [CB-1:0] cls;
    int guard;
    logic [23:0] boundary [5];

    rst_n = 1'b0;
    pclk0 = 0; dat0 = 0; we0 = 0; pclk1 = 0; dat1 = 0; we1 = 0;
    bus0.nn_done = 0; bus0.nn_class = '0; bus1.nn_done = 0; bus1.nn_class = '0;
    tick(3);
    chk("rst_mask_we", bus0.mask_we, 0);
    chk("rst_mask_addr", bus0.mask_addr, 0);
    chk("rst_nn_start", bus0.nn_start, 0);
    chk("rst_result_valid", rv0, 0);
    chk("rst_frame_count", fc0, 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    tick(2);

    // Frame 1: all pixels in range.
    for (int i = 0; i < NP0; i++) send_pixel_m(24'hC8800A);
    tick(3);
    check_writes("f1");
    chk("f1_start_count", start_cnt0, 1);
    chk("f1_start_latency", 64'(start_cyc - last_wr_cyc), 1);
    chk("f1_busy", busy0, 1);
    chk("f1_rv_before_done", rv0, 0);
    pulse_done(0, 3'd5);
    chk("f1_result", res0, 5);
    chk("f1_rv", rv0, 1);
    chk("f1_frame_count", fc0, 1);
    chk("f1_idle", busy0, 0);

    // Frame 2: inclusive-boundary pixels plus random ones.
    boundary[0] = {8'd200, 8'd128, 8'd26};
    boundary[1] = {8'd60,  8'd40,  8'd25};
    boundary[2] = {8'd255, 8'd255, 8'd0};
    boundary[3] = {8'd59,  8'd40,  8'd25};
    boundary[4] = {8'd60,  8'd39,  8'd25};
    for (int i = 0; i < 5; i++) send_pixel_m(boundary[i]);
    for (int i = 5; i < NP0; i++) send_pixel_m(rand_px());
    tick(3);
    check_writes("f2");
    chk("f2_start_count", start_cnt0, 2);

    // Edges while waiting for the network are dropped and flagged.
    chk("ovr_before", ov0, 0);
    for (int i = 0; i < 10; i++) send_bit(0, 1'($urandom_range(1, 0)));
    tick(2);
    chk("ovr_set", ov0, 1);
    chk("ovr_busy", busy0, 1);
    check_writes("ovr");
    cls = 3'($urandom_range(7, 0));
    pulse_done(0, cls);
    chk("f2_result", res0, 64'(cls));
    chk("f2_frame_count", fc0, 2);

    // Frame 3: random pixels, must start again at address 0.
    for (int i = 0; i < NP0; i++) send_pixel_m(rand_px());
    tick(3);
    check_writes("f3");
    cls = 3'($urandom_range(7, 0));
    pulse_done(0, cls);
    chk("f3_result", res0, 64'(cls));
    chk("f3_frame_count", fc0, 3);
    chk("f3_overrun_sticky", ov0, 1);

    // Watchdog: one full pixel then 6 stray bits, then silence.
    send_pixel_m(rand_px());
    for (int i = 0; i < 6; i++) send_bit(0, 1'b1);
    tick(40);
    chk("to_early", to0, 0);
    tick(20);
    chk("to_set", to0, 1);
    chk("to_idle", busy0, 0);
    chk("to_no_start", start_cnt0, 3);
    check_writes("to");
    model_addr = 0;

    // write_enable low mid-pixel holds the partial pixel.
    px = rand_px();
    for (int k = 0; k < 10; k++) send_bit(0, px[k]);
    we0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dat0 = ~dat0; pclk0 = 1'b1; tick(2); pclk0 = 1'b0; tick(2);
    end
    for (int k = 10; k < 24; k++) send_bit(0, px[k]);
    expect_pixel(px);
    send_pixel_m(rand_px());
    tick(2);
    check_writes("we_hold");

    // Asynchronous reset in the middle of pixel 2's capture.
    px = rand_px();
    for (int k = 0; k < 12; k++) send_bit(0, px[k]);
    chk("pre_rst_frame_count", fc0, 3);
    chk("pre_rst_addr", bus0.mask_addr, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_timeout_err", to0, 0);
    chk("arst_overrun", ov0, 0);
    chk("arst_frame_count", fc0, 0);
    chk("arst_result", res0, 0);
    chk("arst_result_valid", rv0, 0);
    chk("arst_mask_addr", bus0.mask_addr, 0);
    chk("arst_mask_bit", bus0.mask_bit, 0);
    chk("arst_busy", busy0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    model_addr = 0;
    wr_addr_q.delete(); wr_bit_q.delete();
    send_pixel_m(rand_px());
    tick(2);
    check_writes("post_rst");

    // 1x1 instance: every pixel ends a frame; frame_count must wrap.
    cls = '0;
    for (int f = 0; f < 256; f++) begin
      send_pixel(1, rand_px());
      guard = 0;
      while (busy1 !== 1'b1 && guard < 20) begin tick(1); guard++; end
      if (guard >= 20) chk("wrap_busy_wait", busy1, 1);
      tick(2);
      cls = 3'($urandom_range(7, 0));
      pulse_done(1, cls);
      if (f == 0)   chk("wrap_fc_first", fc1, 1);
      if (f == 254) chk("wrap_fc_255", fc1, 255);
    end
    chk("wrap_fc_zero", fc1, 0);
    chk("wrap_result", res1, 64'(cls));
    chk("wrap_rv", rv1, 1);
    chk("wrap_writes", wr_cnt1, 256);
    chk("wrap_starts", start_cnt1, 256);
    chk("wrap_no_overrun", ov1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
